// File: rtl/tnn_core_arbiter.sv
// Round-robin share of one TNN classifier core: grant, capture features, wait CORE_LAT+1 edges, return class.
// One transaction per CORE_LAT+3 cycles; requests stall while busy, the response holds until rsp_ready.
module tnn_core_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CORE_LAT = 0,
  parameter int CNT_W    = 16,
  parameter int ID_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*18-1:0]   req_data,
  output logic [17:0]           core_feat,
  input  logic                  core_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_class,
  output logic                  busy,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_total,
  output logic [CNT_W-1:0]      cnt_pos
);

  typedef struct packed {
    logic [2:0] f;
    logic [2:0] e;
    logic [2:0] d;
    logic [2:0] c;
    logic [2:0] b;
    logic [2:0] a;
  } feat_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0]      LAT_INIT   = 3'(CORE_LAT);
  localparam logic [ID_W-1:0] GRANT_INIT = ID_W'(N_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            any_req;
  feat_t           win_feat;
  feat_t           feat_q;
  logic [2:0]      wait_cnt;
  logic            grant;
  logic            rsp_hs;
  int              idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    win_feat = '0;
    idx      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req  = 1'b1;
        winner   = ID_W'(idx);
        win_feat = req_data[idx*18 +: 18];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[winner] = 1'b1;
          state_nxt         = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant     = (state == IDLE) && any_req;
  assign rsp_hs    = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);
  assign core_feat = feat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q     <= '0;
      rsp_id     <= '0;
      last_grant <= GRANT_INIT;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_class  <= 1'b0;
    end else begin
      if (grant) begin
        feat_q     <= win_feat;
        rsp_id     <= winner;
        last_grant <= winner;
        wait_cnt   <= LAT_INIT;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == WAIT && wait_cnt == '0) begin
        rsp_class <= core_result;
        rsp_valid <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Clear wins over a coincident handshake; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total <= '0;
      cnt_pos   <= '0;
    end else if (clr_cnt) begin
      cnt_total <= '0;
      cnt_pos   <= '0;
    end else if (rsp_hs) begin
      if (cnt_total != '1)            cnt_total <= cnt_total + 1'b1;
      if (rsp_class && cnt_pos != '1) cnt_pos   <= cnt_pos + 1'b1;
    end
  end

endmodule

// File: tb/tb_tnn_core_arbiter.sv
// Bench for tnn_core_arbiter: a combinational-core instance (a) and a 3-stage-core instance (b).
module tb_tnn_core_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic           c;
  } rsp_t;

  rsp_t q_a[$];
  rsp_t q_b[$];

  logic            rst_n_a, rst_n_b;
  logic [N-1:0]    req_valid_a, req_ready_a, req_valid_b, req_ready_b;
  logic [N*18-1:0] req_data_a, req_data_b;
  logic [17:0]     core_feat_a, core_feat_b;
  logic            core_result_a, core_result_b;
  logic            rsp_valid_a, rsp_ready_a, rsp_valid_b, rsp_ready_b;
  logic [IDW-1:0]  rsp_id_a, rsp_id_b;
  logic            rsp_class_a, rsp_class_b, busy_a, busy_b, clr_cnt_a, clr_cnt_b;
  logic [15:0]     cnt_total_a, cnt_pos_a;
  logic [3:0]      cnt_total_b, cnt_pos_b;

  tnn_core_arbiter #(.N_REQ(N), .CORE_LAT(0), .CNT_W(16), .ID_W(IDW)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_data(req_data_a), .core_feat(core_feat_a), .core_result(core_result_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_id(rsp_id_a),
    .rsp_class(rsp_class_a), .busy(busy_a), .clr_cnt(clr_cnt_a),
    .cnt_total(cnt_total_a), .cnt_pos(cnt_pos_a)
  );

  tnn_core_arbiter #(.N_REQ(N), .CORE_LAT(3), .CNT_W(4), .ID_W(IDW)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_data(req_data_b), .core_feat(core_feat_b), .core_result(core_result_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
    .rsp_class(rsp_class_b), .busy(busy_b), .clr_cnt(clr_cnt_b),
    .cnt_total(cnt_total_b), .cnt_pos(cnt_pos_b)
  );

  // Stand-in classifier: odd parity of the 18 feature bits.
  function automatic logic cls(input logic [17:0] x);
    return ^x;
  endfunction

  assign core_result_a = cls(core_feat_a);

  logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
  always @(posedge clk) begin
    p1 <= cls(core_feat_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign core_result_b = p3;

  function automatic rsp_t mk(input int id, input logic c);
    rsp_t r;
    r.id = IDW'(id);
    r.c  = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n_a && rsp_valid_a && rsp_ready_a) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_rsp: got id %0d, expected no response", rsp_id_a);
      end else begin
        e = q_a.pop_front();
        check("a_rsp_id", 32'(rsp_id_a), 32'(e.id));
        check("a_rsp_class", 32'(rsp_class_a), 32'(e.c));
      end
    end
    if (rst_n_b && rsp_valid_b && rsp_ready_b) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_rsp: got id %0d, expected no response", rsp_id_b);
      end else begin
        e = q_b.pop_front();
        check("b_rsp_id", 32'(rsp_id_b), 32'(e.id));
        check("b_rsp_class", 32'(rsp_class_b), 32'(e.c));
      end
    end
    check("a_onehot", 32'($countones(req_ready_a) <= 1), 1);
    check("b_onehot", 32'($countones(req_ready_b) <= 1), 1);
  end

  // One request on instance b; returns edges from capture to rsp_valid.
  task automatic txn_b(input int id, input logic c, output int n);
    @(posedge clk); #1;
    req_valid_b = 4'b0001 << id;
    q_b.push_back(mk(id, c));
    @(negedge clk);
    check("b_grant", 32'(req_ready_b), 32'(4'b0001 << id));
    @(posedge clk); #1;
    req_valid_b = '0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid_b) break;
      @(posedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  localparam logic [17:0] D0 = {3'b010, 3'b011, 3'b001, 3'b110, 3'b001, 3'b101};

  initial begin
    int g, last, n, id;
    logic [3:0] cls_tab;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_valid_a = '0; req_valid_b = '0; req_data_a = '0; req_data_b = '0;
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1; clr_cnt_a = 1'b0; clr_cnt_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n_a = 1'b1; rst_n_b = 1'b1;

    @(negedge clk);
    check("rst_req_ready", 32'(req_ready_a), 0);
    check("rst_core_feat", 32'(core_feat_a), 0);
    check("rst_rsp_valid", 32'(rsp_valid_a), 0);
    check("rst_rsp_id", 32'(rsp_id_a), 0);
    check("rst_rsp_class", 32'(rsp_class_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_cnt_total", 32'(cnt_total_a), 0);
    check("rst_cnt_pos", 32'(cnt_pos_a), 0);

    // Single request, combinational core, D0 has nine ones -> class 1.
    @(posedge clk); #1;
    req_data_a[17:0] = D0;
    req_valid_a = 4'b0001;
    q_a.push_back(mk(0, 1'b1));
    @(negedge clk);
    check("t1_grant", 32'(req_ready_a), 32'h1);
    @(posedge clk); #1;
    req_valid_a = '0;
    @(negedge clk);
    check("t1_core_feat", 32'(core_feat_a), 32'(D0));
    check("t1_busy", 32'(busy_a), 1);
    check("t1_rsp_early", 32'(rsp_valid_a), 0);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid_a), 1);
    @(negedge clk);
    check("t1_cnt_total", 32'(cnt_total_a), 1);
    check("t1_cnt_pos", 32'(cnt_pos_a), 1);
    check("t1_idle", 32'(busy_a), 0);

    // All four valid; last grant was 0 so order is 1,2,3,0,... every 3 cycles.
    req_data_a = {18'h3FFFF, 18'h00007, 18'h00003, 18'h00001};
    cls_tab = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      id = (1 + k) % N;
      q_a.push_back(mk(id, cls_tab[id]));
    end
    @(posedge clk); #1;
    req_valid_a = 4'hF;
    g = 0; last = 0;
    for (int cyc = 0; cyc < 40 && g < 8; cyc++) begin
      @(negedge clk);
      if (req_ready_a != '0) begin
        id = (1 + g) % N;
        check("t2_order", 32'(req_ready_a), 32'(4'b0001 << id));
        if (g > 0) check("t2_spacing", 32'(cyc - last), 3);
        last = cyc;
        g++;
      end
    end
    check("t2_grants_seen", 32'(g), 8);
    @(posedge clk); #1;
    req_valid_a = '0;
    repeat (4) @(negedge clk);
    check("t2_cnt_total", 32'(cnt_total_a), 9);
    check("t2_cnt_pos", 32'(cnt_pos_a), 5);

    // Backpressure: response from requester 1 held for 10 cycles while 2 and 3 wait.
    req_data_a[35:18] = 18'h10000;
    rsp_ready_a = 1'b0;
    @(posedge clk); #1;
    req_valid_a = 4'b0010;
    q_a.push_back(mk(1, 1'b1));
    @(negedge clk);
    check("t4_grant1", 32'(req_ready_a), 32'h2);
    @(posedge clk); #1;
    req_valid_a = 4'b1100;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid_a), 1);
      check("t4_hold_id", 32'(rsp_id_a), 1);
      check("t4_hold_class", 32'(rsp_class_a), 1);
      check("t4_no_grant", 32'(req_ready_a), 0);
      if (k == 5) req_valid_a[3] = 1'b0;
    end
    @(posedge clk); #1;
    rsp_ready_a = 1'b1;
    q_a.push_back(mk(2, 1'b1));
    @(negedge clk);
    check("t4_no_grant_hs", 32'(req_ready_a), 0);
    @(negedge clk);
    check("t4_grant2", 32'(req_ready_a), 32'h4);
    @(posedge clk); #1;
    req_valid_a = '0;
    repeat (3) @(negedge clk);
    check("t4_cnt_total", 32'(cnt_total_a), 11);
    check("t4_cnt_pos", 32'(cnt_pos_a), 7);

    // Three-stage core: alternating classes expose a stale sample.
    req_data_b = {18'h00003, 18'h00001, 18'h00000, 18'h00001};
    txn_b(0, 1'b1, n);
    check("b_lat_0", 32'(n), 4);
    txn_b(1, 1'b0, n);
    check("b_lat_1", 32'(n), 4);
    txn_b(2, 1'b1, n);
    check("b_lat_2", 32'(n), 4);
    check("b_cnt_total3", 32'(cnt_total_b), 3);
    check("b_cnt_pos2", 32'(cnt_pos_b), 2);

    @(posedge clk); #1 clr_cnt_b = 1'b1;
    @(posedge clk); #1 clr_cnt_b = 1'b0;
    @(negedge clk);
    check("b_clr_total", 32'(cnt_total_b), 0);
    check("b_clr_pos", 32'(cnt_pos_b), 0);

    // 4-bit counters: 14 responses, then two more saturate at 4'hF.
    for (int k = 0; k < 14; k++) txn_b(0, 1'b1, n);
    check("b_cnt_total14", 32'(cnt_total_b), 14);
    check("b_cnt_pos14", 32'(cnt_pos_b), 14);
    txn_b(0, 1'b1, n);
    check("b_cnt_total15", 32'(cnt_total_b), 15);
    txn_b(0, 1'b1, n);
    check("b_sat_total", 32'(cnt_total_b), 15);
    check("b_sat_pos", 32'(cnt_pos_b), 15);

    // Clear coincident with a handshake.
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
    req_valid_b = 4'b0001;
    q_b.push_back(mk(0, 1'b1));
    @(posedge clk); #1;
    req_valid_b = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("b_resp_wait", 32'(rsp_valid_b), 1);
    @(posedge clk); #1;
    rsp_ready_b = 1'b1;
    clr_cnt_b = 1'b1;
    @(posedge clk); #1;
    clr_cnt_b = 1'b0;
    @(negedge clk);
    check("b_clr_hs_total", 32'(cnt_total_b), 0);
    check("b_clr_hs_pos", 32'(cnt_pos_b), 0);
    check("b_clr_hs_idle", 32'(busy_b), 0);

    // Async reset while waiting on the core.
    @(posedge clk); #1;
    req_valid_b = 4'b1000;
    @(posedge clk); #1;
    req_valid_b = '0;
    @(posedge clk); #2;
    rst_n_b = 1'b0;
    #1;
    check("b_arst_busy", 32'(busy_b), 0);
    check("b_arst_feat", 32'(core_feat_b), 0);
    check("b_arst_id", 32'(rsp_id_b), 0);
    check("b_arst_valid", 32'(rsp_valid_b), 0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b_no_rsp_after_rst", 32'(rsp_valid_b), 0);
    end
    @(posedge clk); #1;
    req_valid_b = 4'hF;
    q_b.push_back(mk(0, 1'b1));
    @(negedge clk);
    check("b_post_rst_grant", 32'(req_ready_b), 32'h1);
    @(posedge clk); #1;
    req_valid_b = '0;
    repeat (8) @(negedge clk);

    check("a_queue_drained", 32'(q_a.size()), 0);
    check("b_queue_drained", 32'(q_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule

// File: doc/tnn_core_arbiter.md
Name: tnn_core_arbiter

Overview:
- Shares one combinational/pipelined TNN classifier core (six 3-bit features in, 1-bit class out) among N_REQ requesters.
- Round-robin arbitrates requests, registers the winning feature vector onto the core inputs, waits the core latency, then returns the class bit tagged with the requester ID over a valid/ready response channel.
- Keeps saturating classification statistics.
- Sits between the sample-distribution fabric and the evolved classifier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CORE_LAT, 0, register stages inside the attached core (0..7); 0 = purely combinational
- CNT_W, 16, width of statistics counters
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
- req_data  in  N_REQ*18  requester i at [i*18 +: 18]; feature a=[2:0], b=[5:3], c=[8:6], d=[11:9], e=[14:12], f=[17:15]
- core_feat  out  18  registered feature vector to core, same a..f layout
- core_result  in  1  class bit from core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of response
- rsp_class  out  1  sampled class bit
- busy  out  1  high in any state except IDLE
- clr_cnt  in  1  synchronous clear of statistics
- cnt_total  out  CNT_W  completed responses
- cnt_pos  out  CNT_W  completed responses with rsp_class=1

Behaviour:
- Reset: state=IDLE; req_ready=0; core_feat=0; rsp_valid=0; rsp_id=0; rsp_class=0; busy=0; counters=0; last_grant=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no req_valid: stay.
- IDLE, any req_valid:
  - Winner = first asserted index searching from last_grant+1 upward, modulo N_REQ.
  - req_ready[winner]=1 combinationally in that cycle only. That cycle is the handshake; requesters must hold data stable while valid.
  - On the clock edge: core_feat<=req_data[winner]; rsp_id<=winner; last_grant<=winner; wait_cnt<=CORE_LAT; state->WAIT.
- req_ready is 0 in every state except IDLE; requests arriving during WAIT/RESP stall.
- WAIT:
  - If wait_cnt==0: rsp_class<=core_result; rsp_valid<=1; state->RESP.
  - Else wait_cnt decrements.
  - core_result is therefore sampled CORE_LAT+1 edges after the capture edge.
  - core_feat holds stable from capture until the next grant.
- RESP:
  - rsp_valid=1; rsp_id and rsp_class stable until handshake.
  - On rsp_valid&rsp_ready: rsp_valid<=0; state->IDLE.
  - No grant in the handshake cycle.
- Throughput: one transaction per CORE_LAT+3 cycles with rsp_ready tied high.
- Statistics:
  - On each response handshake: cnt_total+=1; cnt_pos+=rsp_class.
  - Each counter saturates at all-ones and holds.
  - clr_cnt sets both counters to 0 at the next edge. It has priority over a simultaneous handshake: the result is 0, not 1.
- Requester dropping req_valid before grant: that request is ignored; no state change.
- Round-robin fairness: a continuously requesting set is served in cyclic order. Any requester waits at most N_REQ-1 transactions.
- Asynchronous reset mid-transaction: the in-flight request is discarded, no response is issued, and all outputs return to reset values immediately.
- busy = (state!=IDLE).

Test Plan:
- Single request, CORE_LAT=0: req_valid=4'b0001, data a=3'b101..f=3'b010, core model returns 1 → req_ready[0] high in cycle 0; core_feat=data at cycle 1; rsp_valid at cycle 2 with rsp_id=0, rsp_class=1; cnt_total=1, cnt_pos=1 after handshake.
- All four requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0,...; each grant 3 cycles apart; req_ready never more than one bit high.
- CORE_LAT=3 with a 3-stage core model → rsp_valid rises exactly 4 edges after capture; rsp_class matches the pipelined model output, not the stale value.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_id and rsp_class stable; req_ready=0 throughout; requester 2 valid meanwhile is granted only after the handshake plus return to IDLE.
- Counters: preload to 0xFFFE via 2^16-2 transactions (or forced), two more class=1 responses → both counters hold 0xFFFF; clr_cnt coincident with a handshake → both counters 0.
- Async reset asserted in WAIT → outputs zero immediately, no rsp_valid after release; first post-reset grant goes to requester 0 when all are valid.
